// File: rtl/jtldtest_ioctl_src.sv
// Download-stream generator for the SDRAM load test: two identical passes of an
// LFSR byte sequence (write, then check), with optional single-byte corruption.
module jtldtest_ioctl_src #(
    parameter int unsigned      AW       = 25,
    parameter int unsigned      LEN      = 32'h0200_0000,
    parameter int unsigned      WR_GAP   = 8,
    parameter int unsigned      PASS_GAP = 64,
    parameter logic [15:0]      SEED     = 16'hACE1,
    parameter logic [AW-1:0]    INJ_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    input  logic          inject,
    output logic          downloading,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_dout,
    output logic          ioctl_wr,
    output logic          pass,
    output logic          done
);
    localparam int unsigned   CW        = $clog2(WR_GAP);
    localparam int unsigned   GW        = $clog2(PASS_GAP);
    localparam logic [CW-1:0] CYC_LAST  = CW'(WR_GAP - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(PASS_GAP - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cyc;
    logic [GW-1:0]   gap_cnt;
    logic [15:0]     lfsr;
    logic            inj_armed;
    logic [15:0]     lfsr_nxt;
    logic [AW-1:0]   addr_nxt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [7:0] byte_out(input logic [15:0] v, input logic flip);
        return v[7:0] ^ {7'd0, flip};
    endfunction

    always_comb begin
        lfsr_nxt = lfsr_step(lfsr);
        addr_nxt = ioctl_addr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            downloading <= 1'b0;
            ioctl_addr  <= '0;
            ioctl_dout  <= 8'd0;
            ioctl_wr    <= 1'b0;
            pass        <= 1'b0;
            done        <= 1'b0;
            inj_armed   <= 1'b0;
            cyc         <= '0;
            gap_cnt     <= '0;
            lfsr        <= SEED;
        end else begin
            ioctl_wr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        downloading <= 1'b1;
                        ioctl_addr  <= '0;
                        ioctl_dout  <= SEED[7:0];
                        cyc         <= '0;
                        lfsr        <= SEED;
                        pass        <= 1'b0;
                        done        <= 1'b0;
                        inj_armed   <= 1'b0;
                    end
                end
                RUN: begin
                    // Byte pacing freezes under hold so addr/dout stay put for the checker
                    if (!hold) begin
                        ioctl_wr <= (cyc == CW'(1));
                        if (cyc == CYC_LAST) begin
                            if (ioctl_addr != ADDR_LAST) begin
                                ioctl_addr <= addr_nxt;
                                lfsr       <= lfsr_nxt;
                                ioctl_dout <= byte_out(lfsr_nxt,
                                              pass && inj_armed && (addr_nxt == INJ_ADDR));
                                cyc        <= '0;
                            end else begin
                                state       <= GAP;
                                downloading <= 1'b0;
                                gap_cnt     <= '0;
                            end
                        end else begin
                            cyc <= cyc + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (!pass) begin
                            state       <= RUN;
                            pass        <= 1'b1;
                            inj_armed   <= inject;
                            downloading <= 1'b1;
                            ioctl_addr  <= '0;
                            ioctl_dout  <= byte_out(SEED, inject && (INJ_ADDR == '0));
                            cyc         <= '0;
                            lfsr        <= SEED;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
